// File: rtl/serial_add_ctrl_if.sv
// Operand/result handshake bundle for the bit-serial adder controller.
// Latency: none, wires only.
// Backpressure: in_valid/in_ready toward the controller, out_valid/out_ready from it.
// Optional macro SERIAL_ADD_SUB_EN adds the 1-bit sub select to the bundle.
interface serial_add_ctrl_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             busy;
`ifdef SERIAL_ADD_SUB_EN
  logic             sub;

  // Producer/consumer side (drives operands, accepts the result)
  modport master (
    output in_valid, op_a, op_b, cin, sub, out_ready,
    input  in_ready, out_valid, sum, cout, busy
  );

  // Controller side
  modport slave (
    input  in_valid, op_a, op_b, cin, sub, out_ready,
    output in_ready, out_valid, sum, cout, busy
  );
`else
  // Producer/consumer side (drives operands, accepts the result)
  modport master (
    output in_valid, op_a, op_b, cin, out_ready,
    input  in_ready, out_valid, sum, cout, busy
  );

  // Controller side
  modport slave (
    input  in_valid, op_a, op_b, cin, out_ready,
    output in_ready, out_valid, sum, cout, busy
  );
`endif
endinterface

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder: one full_adder cell walked across WIDTH bits, LSB first.
// Latency: out_valid rises WIDTH clock edges after the operand accept edge.
// Backpressure: result held in DONE until out_ready; no new operands until then.
// Optional macro SERIAL_ADD_SUB_EN adds a sub input (a - b via ~b + 1).

// One-bit full adder cell, the only arithmetic in the block.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (a & ci) | (b & ci);
endmodule

module serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  serial_add_ctrl_if.slave bus
);
  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             carry;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] res;
  logic [WIDTH-1:0] sum_q;
  logic             cout_q;
  logic             out_valid_q;
  logic             busy_q;

  logic             cell_s;
  logic             cell_co;
  logic [WIDTH-1:0] res_next;
  logic [WIDTH-1:0] b_capture;
  logic             carry_capture;

  full_adder u_fa (
    .a  (a_sh[0]),
    .b  (b_sh[0]),
    .ci (carry),
    .s  (cell_s),
    .co (cell_co)
  );

  // Result register shifts right; the freshly computed bit enters at the MSB,
  // so after WIDTH steps bit 0 of the sum has arrived at res[0].
  always_comb begin
    res_next            = res >> 1;
    res_next[WIDTH-1]   = cell_s;
  end

  // Operand B / initial carry as loaded at the accept edge.
  always_comb begin
`ifdef SERIAL_ADD_SUB_EN
    b_capture     = bus.sub ? ~bus.op_b : bus.op_b;
    carry_capture = bus.sub ? 1'b1 : bus.cin;
`else
    b_capture     = bus.op_b;
    carry_capture = bus.cin;
`endif
  end

  // Controller FSM: capture, serial run, hold result until consumed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      carry       <= 1'b0;
      a_sh        <= '0;
      b_sh        <= '0;
      res         <= '0;
      sum_q       <= '0;
      cout_q      <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            a_sh   <= bus.op_a;
            b_sh   <= b_capture;
            carry  <= carry_capture;
            cnt    <= '0;
            res    <= '0;
            state  <= RUN;
            busy_q <= 1'b1;
          end
        end
        RUN: begin
          a_sh  <= a_sh >> 1;
          b_sh  <= b_sh >> 1;
          res   <= res_next;
          carry <= cell_co;
          cnt   <= cnt + CNT_W'(1);
          if (cnt == LAST_BIT) begin
            state       <= DONE;
            sum_q       <= res_next;
            cout_q      <= cell_co;
            out_valid_q <= 1'b1;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            state       <= IDLE;
          end
        end
        default: begin
          // Unreachable encoding: fall back to a clean idle.
          state       <= IDLE;
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = out_valid_q;
  assign bus.sum       = sum_q;
  assign bus.cout      = cout_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed bench for serial_add_ctrl: WIDTH=8 and WIDTH=1 instances.
// Inputs are driven and outputs sampled 1 time unit after the rising edge.
// Subtraction vectors run only when SERIAL_ADD_SUB_EN is defined.
module tb_serial_add_ctrl;
  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  serial_add_ctrl_if #(.WIDTH(8)) bus8 ();
  serial_add_ctrl_if #(.WIDTH(1)) bus1 ();

  serial_add_ctrl #(.WIDTH(8)) dut8 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus8)
  );

  serial_add_ctrl #(.WIDTH(1)) dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Issue one WIDTH=8 operation from an idle DUT; report result and the
  // number of edges from the accept edge until out_valid is seen.
  task automatic do8(input logic [7:0] a, input logic [7:0] b, input logic c,
                     output logic [7:0] s, output logic co, output int lat);
    bus8.op_a     = a;
    bus8.op_b     = b;
    bus8.cin      = c;
    bus8.in_valid = 1'b1;
    @(posedge clk); #1;
    bus8.in_valid = 1'b0;
    lat = 0;
    while (bus8.out_valid !== 1'b1 && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    s  = bus8.sum;
    co = bus8.cout;
  endtask

  task automatic test_reset;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    checks++; if (bus8.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", bus8.in_ready); end
    checks++; if (bus8.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", bus8.out_valid); end
    checks++; if (bus8.sum !== 8'h00 || bus8.cout !== 1'b0) begin errors++; $display("FAIL reset_sum: got %h/%b want 00/0", bus8.sum, bus8.cout); end
    checks++; if (bus8.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", bus8.busy); end
    checks++; if (bus1.in_ready !== 1'b1 || bus1.out_valid !== 1'b0) begin errors++; $display("FAIL reset_w1: got rdy=%b vld=%b want 1/0", bus1.in_ready, bus1.out_valid); end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    checks++; if (bus8.in_ready !== 1'b1 || bus8.out_valid !== 1'b0) begin errors++; $display("FAIL post_reset_idle: got rdy=%b vld=%b want 1/0", bus8.in_ready, bus8.out_valid); end
  endtask

  task automatic test_basic;
    logic [7:0] s; logic co; int lat;
    bus8.out_ready = 1'b1;
    do8(8'h5A, 8'h3C, 1'b0, s, co, lat);
    checks++; if (lat !== 8) begin errors++; $display("FAIL basic_latency: got %0d want 8", lat); end
    checks++; if (s !== 8'h96 || co !== 1'b0) begin errors++; $display("FAIL basic_sum: got %h/%b want 96/0", s, co); end
    checks++; if (bus8.in_ready !== 1'b0 || bus8.busy !== 1'b1) begin errors++; $display("FAIL basic_done_flags: got rdy=%b busy=%b want 0/1", bus8.in_ready, bus8.busy); end
    @(posedge clk); #1;
    checks++; if (bus8.in_ready !== 1'b1 || bus8.out_valid !== 1'b0) begin errors++; $display("FAIL basic_back_idle: got rdy=%b vld=%b want 1/0", bus8.in_ready, bus8.out_valid); end
  endtask

  task automatic test_carry;
    logic [7:0] s; logic co; int lat;
    bus8.out_ready = 1'b1;
    do8(8'hFF, 8'h01, 1'b0, s, co, lat);
    checks++; if (s !== 8'h00 || co !== 1'b1 || lat !== 8) begin errors++; $display("FAIL carry_ff_01: got %h/%b lat %0d want 00/1 lat 8", s, co, lat); end
    @(posedge clk); #1;
    do8(8'hFF, 8'hFF, 1'b1, s, co, lat);
    checks++; if (s !== 8'hFF || co !== 1'b1) begin errors++; $display("FAIL carry_ff_ff_1: got %h/%b want ff/1", s, co); end
    @(posedge clk); #1;
    do8(8'hA5, 8'h5A, 1'b1, s, co, lat);
    checks++; if (s !== 8'h00 || co !== 1'b1) begin errors++; $display("FAIL carry_a5_5a_1: got %h/%b want 00/1", s, co); end
    @(posedge clk); #1;
    do8(8'h00, 8'h00, 1'b1, s, co, lat);
    checks++; if (s !== 8'h01 || co !== 1'b0) begin errors++; $display("FAIL cin_only: got %h/%b want 01/0", s, co); end
    @(posedge clk); #1;
  endtask

  task automatic test_backpressure;
    logic [7:0] s; logic co; int lat; bit seen;
    bus8.out_ready = 1'b0;
    do8(8'h12, 8'h34, 1'b0, s, co, lat);
    checks++; if (s !== 8'h46 || co !== 1'b0 || lat !== 8) begin errors++; $display("FAIL bp_sum: got %h/%b lat %0d want 46/0 lat 8", s, co, lat); end
    for (int i = 0; i < 5; i++) begin
      bus8.in_valid = (i % 2 == 0);
      bus8.op_a     = 8'hFF;
      bus8.op_b     = 8'hFF;
      @(posedge clk); #1;
      checks++;
      if (bus8.out_valid !== 1'b1 || bus8.sum !== 8'h46 || bus8.cout !== 1'b0 || bus8.in_ready !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold[%0d]: got vld=%b sum=%h cout=%b rdy=%b want 1/46/0/0", i, bus8.out_valid, bus8.sum, bus8.cout, bus8.in_ready);
      end
    end
    bus8.in_valid  = 1'b0;
    bus8.out_ready = 1'b1;
    @(posedge clk); #1;
    checks++; if (bus8.out_valid !== 1'b0 || bus8.in_ready !== 1'b1) begin errors++; $display("FAIL bp_release: got vld=%b rdy=%b want 0/1", bus8.out_valid, bus8.in_ready); end
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (bus8.out_valid === 1'b1 || bus8.busy === 1'b1) seen = 1'b1;
    end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL bp_not_queued: got activity=%b want 0", seen); end
  endtask

  task automatic test_reset_mid;
    logic [7:0] s; logic co; int lat; bit seen;
    bus8.out_ready = 1'b1;
    bus8.op_a      = 8'hAA;
    bus8.op_b      = 8'h55;
    bus8.cin       = 1'b0;
    bus8.in_valid  = 1'b1;
    @(posedge clk); #1;
    bus8.in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (bus8.out_valid !== 1'b0 || bus8.sum !== 8'h00 || bus8.cout !== 1'b0 || bus8.busy !== 1'b0 || bus8.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL mid_reset: got vld=%b sum=%h cout=%b busy=%b rdy=%b want 0/00/0/0/1", bus8.out_valid, bus8.sum, bus8.cout, bus8.busy, bus8.in_ready);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (bus8.out_valid === 1'b1) seen = 1'b1;
    end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL mid_reset_discard: got out_valid seen=%b want 0", seen); end
    do8(8'h01, 8'h01, 1'b0, s, co, lat);
    checks++; if (s !== 8'h02 || co !== 1'b0 || lat !== 8) begin errors++; $display("FAIL after_reset_op: got %h/%b lat %0d want 02/0 lat 8", s, co, lat); end
    @(posedge clk); #1;
  endtask

  task automatic test_width1;
    int lat; int acc_cnt; int acc_idx[8]; bit bad;
    bus1.out_ready = 1'b1;
    bus1.op_a      = 1'b1;
    bus1.op_b      = 1'b1;
    bus1.cin       = 1'b1;
    bus1.in_valid  = 1'b1;
    @(posedge clk); #1;
    bus1.in_valid = 1'b0;
    lat = 0;
    while (bus1.out_valid !== 1'b1 && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    checks++; if (lat !== 1) begin errors++; $display("FAIL w1_latency: got %0d want 1", lat); end
    checks++; if (bus1.sum !== 1'b1 || bus1.cout !== 1'b1) begin errors++; $display("FAIL w1_sum: got %b/%b want 1/1", bus1.sum, bus1.cout); end
    @(posedge clk); #1;
    // Back-to-back: in_valid held high, 1 + 0 + 1 = 2 -> sum 0, cout 1.
    bus1.op_a     = 1'b1;
    bus1.op_b     = 1'b0;
    bus1.cin      = 1'b1;
    bus1.in_valid = 1'b1;
    acc_cnt = 0;
    bad     = 1'b0;
    for (int k = 0; k < 12; k++) begin
      if (bus1.in_ready === 1'b1 && acc_cnt < 8) begin
        acc_idx[acc_cnt] = k;
        acc_cnt++;
      end
      if (bus1.out_valid === 1'b1 && (bus1.sum !== 1'b0 || bus1.cout !== 1'b1)) bad = 1'b1;
      @(posedge clk); #1;
    end
    bus1.in_valid = 1'b0;
    checks++; if (acc_cnt !== 4) begin errors++; $display("FAIL w1_b2b_count: got %0d want 4", acc_cnt); end
    for (int j = 1; j < 4; j++) begin
      checks++;
      if (j < acc_cnt && acc_idx[j] - acc_idx[j-1] !== 3) begin
        errors++;
        $display("FAIL w1_b2b_spacing[%0d]: got %0d want 3", j, acc_idx[j] - acc_idx[j-1]);
      end
    end
    checks++; if (bad !== 1'b0) begin errors++; $display("FAIL w1_b2b_sum: got bad result flag %b want 0", bad); end
    repeat (3) @(posedge clk);
    #1;
  endtask

`ifdef SERIAL_ADD_SUB_EN
  task automatic test_sub;
    logic [7:0] s; logic co; int lat;
    bus8.out_ready = 1'b1;
    bus8.sub       = 1'b1;
    do8(8'h10, 8'h01, 1'b0, s, co, lat);
    checks++; if (s !== 8'h0F || co !== 1'b1 || lat !== 8) begin errors++; $display("FAIL sub_10_01: got %h/%b lat %0d want 0f/1 lat 8", s, co, lat); end
    @(posedge clk); #1;
    do8(8'h01, 8'h02, 1'b1, s, co, lat);
    checks++; if (s !== 8'hFF || co !== 1'b0) begin errors++; $display("FAIL sub_01_02: got %h/%b want ff/0", s, co); end
    @(posedge clk); #1;
    bus8.sub = 1'b0;
    do8(8'h10, 8'h01, 1'b0, s, co, lat);
    checks++; if (s !== 8'h11 || co !== 1'b0) begin errors++; $display("FAIL sub0_add: got %h/%b want 11/0", s, co); end
    @(posedge clk); #1;
  endtask
`endif

  initial begin
    checks         = 0;
    errors         = 0;
    bus8.in_valid  = 1'b0;
    bus8.op_a      = '0;
    bus8.op_b      = '0;
    bus8.cin       = 1'b0;
    bus8.out_ready = 1'b0;
    bus1.in_valid  = 1'b0;
    bus1.op_a      = '0;
    bus1.op_b      = '0;
    bus1.cin       = 1'b0;
    bus1.out_ready = 1'b0;
`ifdef SERIAL_ADD_SUB_EN
    bus8.sub       = 1'b0;
    bus1.sub       = 1'b0;
`endif
    test_reset;
    test_basic;
    test_carry;
    test_backpressure;
    test_reset_mid;
    test_width1;
`ifdef SERIAL_ADD_SUB_EN
    test_sub;
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
